// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: three-stage two-level carry-lookahead adder/subtractor.
// 4-bit groups, 16-bit super-groups; carries ripple only between super-groups.
module cla_adder_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NG = WIDTH / 4;
    localparam int NS = (NG + 3) / 4;

    generate
        if (WIDTH != 4 && WIDTH != 8 && WIDTH != 16 &&
            WIDTH != 32 && WIDTH != 64) begin : g_bad_width
            $error("cla_adder_pipe: WIDTH must be 4, 8, 16, 32 or 64");
        end
    endgenerate

    logic             adv;
    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] g1;
    logic             cin1;
    logic [NG-1:0]    gc_n;
    logic [WIDTH-1:0] p2;
    logic [WIDTH-1:0] g2;
    logic [NG-1:0]    gc2;
    logic [WIDTH-1:0] c_n;
    logic [WIDTH-1:0] sum_n;
    logic             cout_n;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv & !rst;
    assign bx       = in_b ^ {WIDTH{in_sub}};

    // Lookahead: group P/G, super-group P/G, super-group ripple, group carry-ins
    always_comb begin
        logic [4*NS-1:0] gp;
        logic [4*NS-1:0] gg;
        logic [4*NS-1:0] gcx;
        logic            sgp;
        logic            sgg;
        logic            sc;
        gp  = '1;
        gg  = '0;
        gcx = '0;
        sgp = 1'b0;
        sgg = 1'b0;
        sc  = cin1;
        for (int i = 0; i < NG; i++) begin
            gp[i] = &p1[4*i +: 4];
            gg[i] = g1[4*i+3]
                  | (p1[4*i+3] & g1[4*i+2])
                  | (p1[4*i+3] & p1[4*i+2] & g1[4*i+1])
                  | (p1[4*i+3] & p1[4*i+2] & p1[4*i+1] & g1[4*i]);
        end
        for (int s = 0; s < NS; s++) begin
            gcx[4*s]   = sc;
            gcx[4*s+1] = gg[4*s]
                       | (gp[4*s] & sc);
            gcx[4*s+2] = gg[4*s+1]
                       | (gp[4*s+1] & gg[4*s])
                       | (gp[4*s+1] & gp[4*s] & sc);
            gcx[4*s+3] = gg[4*s+2]
                       | (gp[4*s+2] & gg[4*s+1])
                       | (gp[4*s+2] & gp[4*s+1] & gg[4*s])
                       | (gp[4*s+2] & gp[4*s+1] & gp[4*s] & sc);
            sgp = &gp[4*s +: 4];
            sgg = gg[4*s+3]
                | (gp[4*s+3] & gg[4*s+2])
                | (gp[4*s+3] & gp[4*s+2] & gg[4*s+1])
                | (gp[4*s+3] & gp[4*s+2] & gp[4*s+1] & gg[4*s]);
            sc  = sgg | (sgp & sc);
        end
        gc_n = gcx[NG-1:0];
    end

    // Per-bit carries inside each group from its registered carry-in
    always_comb begin
        logic c0;
        c_n    = '0;
        cout_n = 1'b0;
        c0     = 1'b0;
        for (int i = 0; i < NG; i++) begin
            c0         = gc2[i];
            c_n[4*i]   = c0;
            c_n[4*i+1] = g2[4*i]
                       | (p2[4*i] & c0);
            c_n[4*i+2] = g2[4*i+1]
                       | (p2[4*i+1] & g2[4*i])
                       | (p2[4*i+1] & p2[4*i] & c0);
            c_n[4*i+3] = g2[4*i+2]
                       | (p2[4*i+2] & g2[4*i+1])
                       | (p2[4*i+2] & p2[4*i+1] & g2[4*i])
                       | (p2[4*i+2] & p2[4*i+1] & p2[4*i] & c0);
            cout_n     = g2[4*i+3]
                       | (p2[4*i+3] & g2[4*i+2])
                       | (p2[4*i+3] & p2[4*i+2] & g2[4*i+1])
                       | (p2[4*i+3] & p2[4*i+2] & p2[4*i+1] & g2[4*i])
                       | (p2[4*i+3] & p2[4*i+2] & p2[4*i+1] & p2[4*i] & c0);
        end
        sum_n = p2 ^ c_n;
    end

    // S1: capture operands as propagate/generate and effective carry-in
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            p1   <= '0;
            g1   <= '0;
            cin1 <= 1'b0;
        end else if (adv) begin
            v1   <= in_valid;
            p1   <= in_a ^ bx;
            g1   <= in_a & bx;
            cin1 <= in_sub | in_cin;
        end
    end

    // S2: register group carry-ins alongside p and g
    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            p2  <= '0;
            g2  <= '0;
            gc2 <= '0;
        end else if (adv) begin
            v2  <= v1;
            p2  <= p1;
            g2  <= g1;
            gc2 <= gc_n;
        end
    end

    // S3: result registers, loaded only by real beats so bubbles keep old data
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                out_sum  <= sum_n;
                out_cout <= cout_n;
                out_ovf  <= c_n[WIDTH-1] ^ cout_n;
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: randomized and directed checks of cla_adder_pipe
// against an arithmetic reference model, including a width sweep.
`timescale 1ns/1ps
module tb_cla_adder_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    logic        sw_valid;
    logic [63:0] sw_a;
    logic [63:0] sw_b;
    logic        sw_sub;
    logic        sw_cin;
    logic        r4, r8, r16, r64;
    logic        v4, v8, v16, v64;
    logic [3:0]  s4;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic [63:0] s64;
    logic        c4, c8, c16, c64;
    logic        f4, f8, f16, f64;

    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          npush = 0;
    int          npop = 0;
    logic [33:0] q[$];
    int          pop_cyc[$];

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    cla_adder_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(sw_valid), .in_ready(r4),
        .in_a(sw_a[3:0]), .in_b(sw_b[3:0]), .in_sub(sw_sub), .in_cin(sw_cin),
        .out_valid(v4), .out_ready(1'b1),
        .out_sum(s4), .out_cout(c4), .out_ovf(f4)
    );

    cla_adder_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(sw_valid), .in_ready(r8),
        .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_sub(sw_sub), .in_cin(sw_cin),
        .out_valid(v8), .out_ready(1'b1),
        .out_sum(s8), .out_cout(c8), .out_ovf(f8)
    );

    cla_adder_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(sw_valid), .in_ready(r16),
        .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_sub(sw_sub), .in_cin(sw_cin),
        .out_valid(v16), .out_ready(1'b1),
        .out_sum(s16), .out_cout(c16), .out_ovf(f16)
    );

    cla_adder_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(sw_valid), .in_ready(r64),
        .in_a(sw_a), .in_b(sw_b), .in_sub(sw_sub), .in_cin(sw_cin),
        .out_valid(v64), .out_ready(1'b1),
        .out_sum(s64), .out_cout(c64), .out_ovf(f64)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, returns {ovf, cout, sum}
    function automatic logic [65:0] model(int w, logic [63:0] a,
                                          logic [63:0] b, logic sub,
                                          logic cin);
        logic [63:0] m;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [64:0] t;
        logic        c0;
        logic        co;
        logic        ov;
        m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        aa = a & m;
        bb = (sub ? ~b : b) & m;
        c0 = sub ? 1'b1 : cin;
        t  = {1'b0, aa} + {1'b0, bb} + {64'd0, c0};
        co = t[w];
        ov = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
        return {ov, co, t[63:0] & m};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the 32-bit instance
    always @(negedge clk) begin : mon
        logic [65:0] m;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    check("sum", 64'(out_sum), 64'(q[0][31:0]));
                    check("cout", 64'(out_cout), 64'(q[0][32]));
                    check("ovf", 64'(out_ovf), 64'(q[0][33]));
                    void'(q.pop_front());
                    npop++;
                    pop_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) begin
                m = model(32, 64'(in_a), 64'(in_b), in_sub, in_cin);
                q.push_back({m[65], m[64], m[31:0]});
                npush++;
            end
        end
    end

    task automatic drive(logic [31:0] a, logic [31:0] b,
                         logic sub, logic cin);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((q.size() != 0 || out_valid) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 64'(q.size()), 64'd0);
        check("drain_idle", 64'(out_valid), 64'd0);
    endtask

    task automatic one(string tag, logic [31:0] a, logic [31:0] b,
                       logic sub, logic cin, logic [31:0] es,
                       logic ec, logic eo);
        int lat;
        drive(a, b, sub, cin);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 64'(lat), 64'd3);
        check({tag, "_sum"}, 64'(out_sum), 64'(es));
        check({tag, "_cout"}, 64'(out_cout), 64'(ec));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(logic [63:0] a, logic [63:0] b,
                         logic sub, logic cin);
        logic [65:0] m;
        sw_a     = a;
        sw_b     = b;
        sw_sub   = sub;
        sw_cin   = cin;
        sw_valid = 1'b1;
        @(posedge clk);
        #1;
        sw_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        m = model(4, a, b, sub, cin);
        check("w4_valid", 64'(v4), 64'd1);
        check("w4_sum", 64'(s4), m[63:0]);
        check("w4_cout", 64'(c4), 64'(m[64]));
        check("w4_ovf", 64'(f4), 64'(m[65]));
        m = model(8, a, b, sub, cin);
        check("w8_valid", 64'(v8), 64'd1);
        check("w8_sum", 64'(s8), m[63:0]);
        check("w8_cout", 64'(c8), 64'(m[64]));
        check("w8_ovf", 64'(f8), 64'(m[65]));
        m = model(16, a, b, sub, cin);
        check("w16_valid", 64'(v16), 64'd1);
        check("w16_sum", 64'(s16), m[63:0]);
        check("w16_cout", 64'(c16), 64'(m[64]));
        check("w16_ovf", 64'(f16), 64'(m[65]));
        m = model(64, a, b, sub, cin);
        check("w64_valid", 64'(v64), 64'd1);
        check("w64_sum", s64, m[63:0]);
        check("w64_cout", 64'(c64), 64'(m[64]));
        check("w64_ovf", 64'(f64), 64'(m[65]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int pbase;
        int qbase;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_a      = '0;
        sw_b      = '0;
        sw_sub    = 1'b0;
        sw_cin    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(out_sum), 64'd0);
        check("rst_cout", 64'(out_cout), 64'd0);
        check("rst_ovf", 64'(out_ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_sum", 64'(out_sum), 64'd0);
        @(posedge clk);
        #1;

        one("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        one("ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
            32'h8000_0000, 1'b0, 1'b1);
        one("sub", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        one("subcin", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        one("addcin", 32'd10, 32'd20, 1'b0, 1'b1, 32'd31, 1'b0, 1'b0);
        drain();

        base = pop_cyc.size();
        for (int i = 0; i < 8; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        drain();
        check("b2b_count", 64'(pop_cyc.size() - base), 64'd8);
        if (pop_cyc.size() - base == 8) begin
            for (int i = 1; i < 8; i++) begin
                check("b2b_gap",
                      64'(pop_cyc[base+i] - pop_cyc[base+i-1]), 64'd1);
            end
        end

        out_ready = 1'b0;
        pbase = npop;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        end
        in_a     = $urandom;
        in_b     = $urandom;
        in_valid = 1'b1;
        @(negedge clk);
        check("stall_inflight", 64'(q.size()), 64'd3);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_sum", 64'(out_sum), 64'(q[0][31:0]));
            check("stall_cout", 64'(out_cout), 64'(q[0][32]));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        check("stall_count", 64'(npop - pbase), 64'd3);

        pbase = npop;
        drive($urandom, $urandom, 1'b0, 1'b0);
        drive($urandom, $urandom, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(out_sum), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_sum", 64'(out_sum), 64'd0);
        check("post_rst_pops", 64'(npop - pbase), 64'd0);
        @(posedge clk);
        #1;

        pbase = npop;
        qbase = npush;
        for (int i = 0; i < 60; i++) begin
            in_a      = $urandom;
            in_b      = $urandom;
            in_sub    = 1'($urandom_range(0, 1));
            in_cin    = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        drain();
        check("bp_count", 64'(npop - pbase), 64'(npush - qbase));

        sweep({64{1'b1}}, 64'd0, 1'b0, 1'b1);
        check("w64_ones_sum", s64, 64'd0);
        check("w64_ones_cout", 64'(c64), 64'd1);
        check("w8_ones_sum", 64'(s8), 64'd0);
        check("w4_ones_cout", 64'(c4), 64'd1);
        sweep(64'h0F0F_0F0F_0F0F_0F0F, 64'h0101_0101_0101_0101, 1'b0, 1'b0);
        sweep(64'h0F0F_0F0F_0F0F_0F0F, 64'h0101_0101_0101_0101, 1'b1, 1'b0);
        sweep(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        sweep(64'd0, 64'd1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            sweep({$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("sweep_ready", 64'({r4, r8, r16, r64}), 64'hF);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
